// File: rtl/dcache_controller_if.sv
// Bus bundle for the data cache: CPU MEM-stage port plus the block-wide
// request/ack port to off-chip data memory. Signal suffixes are written
// from the cache controller's point of view.
interface dcache_controller_if #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_BITS = 256,
  parameter int DATA_W     = 32
);
  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [DATA_W-1:0]     cpu_data_i;
  logic [DATA_W-1:0]     cpu_data_o;
  logic                  cpu_stall_o;
  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [BLOCK_BITS-1:0] mem_data_o;
  logic [BLOCK_BITS-1:0] mem_data_i;
  logic                  mem_ack_i;

  // Cache controller side
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // Environment side (CPU pipeline and memory)
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally in IDLE; a miss stalls the pipeline,
// writes back a dirty victim if needed, fetches the block, and then lets
// IDLE re-evaluate the same request as a hit on the following cycle.
module dcache_controller #(
  parameter int NUM_LINES  = 16,
  parameter int BLOCK_BITS = 256,
  parameter int ADDR_W     = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_controller_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
  localparam int WSEL_W = $clog2(BLOCK_BITS / DATA_W);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

  // Request address fields; the CPU holds them stable while stalled
  logic [WSEL_W-1:0]     word_sel;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  unused_addr_bits;

  assign word_sel         = bus.cpu_addr_i[OFF_W-1:2];
  assign idx              = bus.cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign req_tag          = bus.cpu_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  logic [BLOCK_BITS-1:0] cur_line;
  logic [DATA_W-1:0]     cur_word;
  logic                  hit;

  assign cur_line = data_q[idx];
  assign cur_word = cur_line[word_sel*DATA_W +: DATA_W];
  assign hit      = (state_q == IDLE) && bus.cpu_req_i && valid_q[idx]
                    && (tag_q[idx] == req_tag);

  logic                  store_en;
  logic                  fill_en;
  logic                  stall;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BLOCK_BITS-1:0] mem_wdata;
  logic [DATA_W-1:0]     rdata;

  // Next-state, line-status updates and bus outputs for the miss FSM
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    store_en  = 1'b0;
    fill_en   = 1'b0;
    stall     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = '0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit) begin
            if (bus.cpu_we_i) begin
              store_en     = 1'b1;
              dirty_d[idx] = 1'b1;
            end else begin
              rdata = cur_word;
            end
          end else begin
            stall   = 1'b1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_q[idx], idx, {OFF_W{1'b0}}};
        mem_wdata = cur_line;
        if (bus.mem_ack_i) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {req_tag, idx, {OFF_W{1'b0}}};
        if (bus.mem_ack_i) begin
          fill_en      = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even with a request pending
  assign bus.cpu_stall_o  = stall  & ~rst_i;
  assign bus.mem_enable_o = mem_en & ~rst_i;
  assign bus.mem_write_o  = mem_wr & ~rst_i;
  assign bus.mem_addr_o   = rst_i ? '0 : mem_addr;
  assign bus.mem_data_o   = rst_i ? '0 : mem_wdata;
  assign bus.cpu_data_o   = rst_i ? '0 : rdata;

  // Control state: FSM and per-line valid/dirty, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag/data arrays: whole-line fill on ack, single-word write on store hit
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      data_q[idx] <= bus.mem_data_i;
      tag_q[idx]  <= req_tag;
    end else if (store_en) begin
      data_q[idx][word_sel*DATA_W +: DATA_W] <= bus.cpu_data_i;
    end
  end

endmodule
